tti_tx_queue: RTL and testbench



---
 rtl/i3c_pkg.sv | 30 +++
 rtl/tti_fifo_mem.sv | 36 +++
 rtl/tti_tx_queue.sv | 175 +++++++++++++++++
 tb/tb_tti_tx_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared types and helpers for the I3C target transaction interface queues.
//
// Contents:
//   rst_state_e  - states of the software-requested queue reset sequence
//   thld_decode  - converts a raw threshold field into an entry count
package i3c_pkg;

    typedef enum logic [1:0] {
        RstIdle,   // normal operation
        RstFlush,  // one cycle: storage emptied, pending word discarded
        RstClear,  // one cycle: write 0 back to the software reset bit
        RstWait    // hold until the reset bit reads back as 0
    } rst_state_e;

    // Raw field to entry count. Power encoding means 2^(thld+1) entries.
    // Large power fields saturate so the result never wraps to a small value.
    function automatic logic [31:0] thld_decode(input logic [31:0] thld, input bit is_pow);
        logic [31:0] eff;
        eff = thld;
        if (is_pow) begin
            if (thld >= 32'd30) begin
                eff = 32'h8000_0000;
            end else begin
                eff = 32'd1 << (thld + 32'd1);
            end
        end
        return eff;
    endfunction

endpackage

// File: rtl/tti_fifo_mem.sv
// Flop-array storage for the TTI queues: one synchronous write port and one
// asynchronous (show-ahead) read port.
//
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - word at raddr_i, combinational
module tti_fifo_mem #(
    parameter int unsigned Depth     = 64,
    parameter int unsigned DataWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [DataWidth-1:0]     wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [DataWidth-1:0]     rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];

    // NOTE: the array has no reset; an entry is only read after it has been
    // written, so clearing it would only cost reset fan-out. Non-blocking
    // assignment keeps the write ordered against readers of the same edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tti_tx_queue.sv
// Transmit-direction TTI queue. CSR writes arrive on a req/ack handshake,
// pass through a one-entry pending register into the FIFO, and leave on a
// valid/ready stream to the target controller. Fill level is compared
// against the ready (free space) and start (occupancy) thresholds, and a
// software queue reset is executed with a hardware self-clear of its bit.
//
// Ports:
//   clk_i, rst_ni                      - clock, async active-low reset
//   req_i, data_i, ack_o               - CSR write handshake
//   rd_valid_o, rd_ready_i, rd_data_o  - controller read stream (show-ahead)
//   ready_thld_i/_o, start_thld_i      - thresholds; _o is the clamped field
//   ready_thld_trig_o                  - free entries >= ready threshold
//   start_thld_trig_o                  - occupied entries >= start threshold
//   full_o, empty_o, depth_o           - occupancy
//   reg_rst_i, reg_rst_we_o/_data_o    - software reset bit and its self-clear
module tti_tx_queue
    import i3c_pkg::*;
#(
    parameter int unsigned Depth     = 64,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ThldWidth = 8,
    parameter int unsigned ThldIsPow = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    input  logic [DataWidth-1:0]       data_i,
    output logic                       ack_o,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [DataWidth-1:0]       rd_data_o,
    input  logic [ThldWidth-1:0]       ready_thld_i,
    output logic [ThldWidth-1:0]       ready_thld_o,
    input  logic [ThldWidth-1:0]       start_thld_i,
    output logic                       ready_thld_trig_o,
    output logic                       start_thld_trig_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] depth_o,
    input  logic                       reg_rst_i,
    output logic                       reg_rst_we_o,
    output logic                       reg_rst_data_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
    localparam bit IsPow = (ThldIsPow != 0);
    // Largest raw field whose decoded value stays below Depth.
    localparam logic [ThldWidth-1:0] ClampRaw =
        IsPow ? ThldWidth'($clog2(Depth) - 2) : ThldWidth'(Depth - 1);

    rst_state_e           state_q, state_d;
    logic                 pend_q;
    logic [DataWidth-1:0] pend_data_q;
    logic                 ack_q;
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [CntW-1:0]      count_q;
    logic                 idle, flushing, push, pop;
    logic [DataWidth-1:0] mem_rdata;
    logic [31:0]          ready_dec, ready_eff, start_eff, count_w, free_w;

    // ---------------- soft-reset FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RstIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        reg_rst_we_o = 1'b0;
        case (state_q)
            RstIdle:  if (reg_rst_i) state_d = RstFlush;
            RstFlush: state_d = RstClear;
            RstClear: begin
                reg_rst_we_o = 1'b1;
                state_d      = RstWait;
            end
            RstWait:  if (!reg_rst_i) state_d = RstIdle;
            default:  state_d = RstIdle;
        endcase
    end

    assign reg_rst_data_o = 1'b0;
    assign idle           = (state_q == RstIdle);
    assign flushing       = (state_q == RstFlush);

    // ---------------- occupancy and handshakes ----------------
    assign full_o     = (count_q == FullCnt);
    assign empty_o    = (count_q == '0);
    assign depth_o    = count_q;
    // Full is judged on the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign push       = pend_q && !full_o && idle;
    assign rd_valid_o = !empty_o && !flushing;
    assign pop        = rd_valid_o && rd_ready_i;
    assign ack_o      = ack_q;
    assign rd_data_o  = rd_valid_o ? mem_rdata : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            ack_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            // A discarded pending word is still acknowledged to release the bus.
            ack_q <= push || (flushing && pend_q);

            if (push || flushing) begin
                pend_q <= 1'b0;
            end
            // A request arriving while one is pending is dropped.
            if (req_i && !pend_q) begin
                pend_q      <= 1'b1;
                pend_data_q <= data_i;
            end

            if (flushing) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    tti_fifo_mem #(
        .Depth     (Depth),
        .DataWidth (DataWidth)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (pend_data_q),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    // ---------------- thresholds ----------------
    always_comb begin
        ready_dec    = thld_decode(32'(ready_thld_i), IsPow);
        ready_eff    = ready_dec;
        ready_thld_o = ready_thld_i;
        if (ready_dec >= Depth) begin
            ready_eff    = Depth - 1;
            ready_thld_o = ClampRaw;
        end
        start_eff = thld_decode(32'(start_thld_i), IsPow);
        count_w   = 32'(count_q);
        free_w    = Depth - count_w;
    end

    assign ready_thld_trig_o = (free_w >= ready_eff);
    assign start_thld_trig_o = (count_w >= start_eff);

    a_no_req_while_pending : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(req_i && pend_q)
    );

endmodule

// File: tb/tb_tti_tx_queue.sv
// Self-checking bench for tti_tx_queue. Written words go to a scoreboard
// queue; every pop on the read stream is compared against its head. A second
// instance with power-encoded thresholds shares the stimulus.
module tb_tti_tx_queue;

    localparam int unsigned Depth = 64;
    localparam int unsigned DW    = 32;
    localparam int unsigned TW    = 8;
    localparam int unsigned CW    = $clog2(Depth+1);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          rd_ready_i = 1'b0;
    logic [TW-1:0] ready_thld_i = '0;
    logic [TW-1:0] start_thld_i = 8'd1;
    logic          reg_rst_i = 1'b0;

    logic          ack_o, rd_valid_o, ready_thld_trig_o, start_thld_trig_o;
    logic          full_o, empty_o, reg_rst_we_o, reg_rst_data_o;
    logic [DW-1:0] rd_data_o;
    logic [TW-1:0] ready_thld_o;
    logic [CW-1:0] depth_o;

    logic          p_ack, p_valid, p_rtrig, p_strig, p_full, p_empty, p_we, p_wd;
    logic [DW-1:0] p_data;
    logic [TW-1:0] p_rthld;
    logic [CW-1:0] p_depth;
    logic [TW-1:0] p_start_thld = 8'd1;
    logic [TW-1:0] p_ready_thld = 8'd0;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] sb[$];
    int            last_lat;

    always #5 clk_i = ~clk_i;

    tti_tx_queue #(.Depth(Depth), .DataWidth(DW), .ThldWidth(TW), .ThldIsPow(0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .ready_thld_i(ready_thld_i), .ready_thld_o(ready_thld_o), .start_thld_i(start_thld_i),
        .ready_thld_trig_o(ready_thld_trig_o), .start_thld_trig_o(start_thld_trig_o),
        .full_o(full_o), .empty_o(empty_o), .depth_o(depth_o), .reg_rst_i(reg_rst_i),
        .reg_rst_we_o(reg_rst_we_o), .reg_rst_data_o(reg_rst_data_o)
    );

    tti_tx_queue #(.Depth(Depth), .DataWidth(DW), .ThldWidth(TW), .ThldIsPow(1)) dut_pow (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i), .ack_o(p_ack),
        .rd_valid_o(p_valid), .rd_ready_i(rd_ready_i), .rd_data_o(p_data),
        .ready_thld_i(p_ready_thld), .ready_thld_o(p_rthld), .start_thld_i(p_start_thld),
        .ready_thld_trig_o(p_rtrig), .start_thld_trig_o(p_strig),
        .full_o(p_full), .empty_o(p_empty), .depth_o(p_depth), .reg_rst_i(reg_rst_i),
        .reg_rst_we_o(p_we), .reg_rst_data_o(p_wd)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Pops are observed mid-cycle, with inputs settled.
    always @(negedge clk_i) begin
        if (rst_ni && rd_valid_o && rd_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(rd_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("rd_data", 64'(rd_data_o), 64'(sb.pop_front()));
            end
        end
    end

    task automatic csr_write(input logic [DW-1:0] d);
        int lat;
        req_i  = 1'b1;
        data_i = d;
        sb.push_back(d);
        lat = 0;
        do begin
            tick();
            req_i = 1'b0;
            lat++;
        end while (!ack_o && lat < 20);
        check("ack_seen", 64'(ack_o), 64'd1);
        last_lat = lat;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready_i = 1'b1;
        while (!empty_o && n < 200) begin
            tick();
            n++;
        end
        rd_ready_i = 1'b0;
        check("drain_empty", 64'(empty_o), 64'd1);
    endtask

    initial begin
        int we_cnt, ack_cnt, blocked_acks;

        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        // Reset state
        check("rst_ack", 64'(ack_o), 64'd0);
        check("rst_rd_valid", 64'(rd_valid_o), 64'd0);
        check("rst_rd_data", 64'(rd_data_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_depth", 64'(depth_o), 64'd0);
        check("rst_we", 64'(reg_rst_we_o), 64'd0);
        check("rst_wdata", 64'(reg_rst_data_o), 64'd0);
        check("rst_ready_trig", 64'(ready_thld_trig_o), 64'd1);
        check("rst_start_trig", 64'(start_thld_trig_o), 64'd0);

        // Single word: ack two cycles after the request, then pop
        csr_write(32'hA5A5_0001);
        check("ack_latency", 64'(last_lat), 64'd2);
        check("one_valid", 64'(rd_valid_o), 64'd1);
        check("one_data", 64'(rd_data_o), 64'hA5A5_0001);
        check("one_start_trig", 64'(start_thld_trig_o), 64'd1);
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        check("one_empty", 64'(empty_o), 64'd1);
        check("one_valid_low", 64'(rd_valid_o), 64'd0);

        // Power-encoded start threshold 1 -> 4 entries
        for (int i = 1; i <= 5; i++) begin
            csr_write(32'h1000_0000 + 32'(i));
            check("pow_depth", 64'(p_depth), 64'(i));
            check("pow_start_trig", 64'(p_strig), 64'(i >= 4));
        end
        drain();

        // Ready threshold 200 clamps to 63
        ready_thld_i = 8'd200;
        #1;
        check("ready_clamp", 64'(ready_thld_o), 64'd63);
        check("ready_trig_d0", 64'(ready_thld_trig_o), 64'd1);
        csr_write(32'h2000_0001);
        check("ready_trig_d1", 64'(ready_thld_trig_o), 64'd1);
        csr_write(32'h2000_0002);
        check("ready_trig_d2", 64'(ready_thld_trig_o), 64'd0);

        // Fill to Depth
        for (int i = 0; i < 80 && !full_o; i++) begin
            csr_write($urandom());
        end
        check("fill_full", 64'(full_o), 64'd1);
        check("fill_depth", 64'(depth_o), 64'(Depth));
        start_thld_i = 8'd65;
        #1;
        check("start_over_depth", 64'(start_thld_trig_o), 64'd0);
        start_thld_i = 8'd1;

        // 65th word stalls while full, goes in after one pop
        req_i  = 1'b1;
        data_i = 32'hC0DE_0065;
        sb.push_back(32'hC0DE_0065);
        tick();
        req_i = 1'b0;
        blocked_acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (ack_o) blocked_acks++;
            tick();
        end
        check("full_no_ack", 64'(blocked_acks), 64'd0);
        check("full_hold", 64'(full_o), 64'd1);
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        begin
            int n;
            n = 0;
            while (!ack_o && n < 10) begin
                tick();
                n++;
            end
        end
        check("late_ack", 64'(ack_o), 64'd1);
        check("late_depth", 64'(depth_o), 64'(Depth));

        // Drain to 10 entries, then soft reset with a pending write
        rd_ready_i = 1'b1;
        repeat (54) tick();
        rd_ready_i = 1'b0;
        check("pre_flush_depth", 64'(depth_o), 64'd10);
        req_i     = 1'b1;
        data_i    = 32'hDEAD_BEEF;
        reg_rst_i = 1'b1;
        tick();
        req_i = 1'b0;
        check("flush_valid_low", 64'(rd_valid_o), 64'd0);
        we_cnt  = 0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (ack_o) ack_cnt++;
            if (reg_rst_we_o) begin
                we_cnt++;
                check("flush_wdata", 64'(reg_rst_data_o), 64'd0);
                reg_rst_i = 1'b0;
            end
            tick();
        end
        reg_rst_i = 1'b0;
        sb.delete();
        check("flush_we_pulses", 64'(we_cnt), 64'd1);
        check("flush_ack", 64'(ack_cnt), 64'd1);
        check("flush_depth", 64'(depth_o), 64'd0);
        check("flush_valid", 64'(rd_valid_o), 64'd0);
        csr_write(32'h3000_0001);
        check("post_flush_data", 64'(rd_data_o), 64'h3000_0001);
        drain();

        // Steady push/pop at depth 32 across pointer wrap
        for (int i = 0; i < 32; i++) csr_write(32'h4000_0000 + 32'(i));
        for (int i = 0; i < 100; i++) begin
            req_i      = 1'b1;
            data_i     = $urandom();
            sb.push_back(data_i);
            rd_ready_i = 1'b0;
            tick();
            req_i      = 1'b0;
            rd_ready_i = 1'b1;
            tick();
            rd_ready_i = 1'b0;
            check("steady_ack", 64'(ack_o), 64'd1);
            check("steady_depth", 64'(depth_o), 64'd32);
        end
        drain();
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Async reset while a write is in flight: no ack, queue empty
        req_i  = 1'b1;
        data_i = 32'h5000_0001;
        tick();
        req_i  = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("arst_ack", 64'(ack_o), 64'd0);
        check("arst_depth", 64'(depth_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        check("arst_no_ack", 64'(ack_o), 64'd0);
        check("arst_empty", 64'(empty_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
